ram_bist: RTL and testbench
===========================

# ram_bist

Built-in self-test initiator for the team's 4x8 synchronous single-port RAM. It drives the RAM's write-enable, address and write-data pins and checks the RAM's registered read data. It runs a two-pass write/read-back/compare sweep over every address and reports pass/fail, an error count and the first failing location. It sits between the top-level test control and the RAM instance, muxed onto the RAM port while `busy` is high.

## Interface
- `AW`, 2, RAM address width (2**AW locations)
- `DW`, 8, RAM data width
- `PATTERN`, 8'hA5, base data pattern (DW bits)

- `clk` in 1: rising-edge clock, shared with the RAM
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a test run, sampled only in IDLE
- `ram_we` out 1: RAM write enable
- `ram_addr` out AW: RAM address
- `ram_din` out DW: RAM write data
- `ram_dout` in DW: RAM registered read data
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse at end of run
- `pass` out 1: last run had zero mismatches
- `err_count` out AW+2: mismatches in last/current run (max 2·2**AW)
- `fail_addr` out AW: address of first mismatch
- `fail_pass` out 1: pass index (0/1) of first mismatch

## Operation
- RAM contract: on each posedge, if `we`=1 the RAM executes `mem[addr] <= din`; else it executes `dout <= mem[addr]`. Read data is valid the cycle after the read address is presented. `dout` holds its value during writes.
- Expected data:
  - pass 0: `D(a) = PATTERN ^ zero_ext(a)`
  - pass 1: `~D(a)`
- States and transitions:
  - IDLE: outputs quiescent. On `start`=1, go to WR and clear `err_count`, `fail_addr`, `fail_pass`, `pass`.
  - WR: `ram_we`=1, `ram_addr`=a, `ram_din`=expected(a). Address increments 0..2**AW-1; after the last address, go to RD with a=0.
  - RD: `ram_we`=0, `ram_addr`=a. Next state CMP.
  - CMP: `ram_we`=0, `ram_addr` holds a. Compare `ram_dout` with expected(a).
    - On mismatch, increment `err_count`. If it was 0 before the increment, also capture `fail_addr`=a and `fail_pass`=current pass.
    - If a < last address: a++ and go to RD.
    - Else, if pass=0: pass=1, a=0, go to WR.
    - Else: go to DONE.
  - DONE: `done`=1, `busy`=0, `pass`<=(`err_count`==0, including any final-CMP increment). Then go to IDLE.
- `busy`=1 in WR, RD and CMP.
- `start` is ignored outside IDLE.
- `ram_we` is 0 in every state except WR.
- The block never reads or writes the RAM in IDLE or DONE.
- `pass`, `err_count`, `fail_addr` and `fail_pass` hold until the next accepted `start`.

## Timing
- Reset values: state IDLE, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_addr`=0, `fail_pass`=0.
- `rst` mid-run: at the next edge, state returns to IDLE and all outputs take reset values. RAM contents are left as-is. A subsequent run is unaffected.
- Run cycle counts, for AW=2 (all outputs registered):
  - Edge E0 samples `start`=1.
  - Cycles 1–4: WR pass 0.
  - Cycles 5–12: RD/CMP pass 0.
  - Cycles 13–16: WR pass 1.
  - Cycles 17–24: RD/CMP pass 1.
  - Cycle 25: DONE.
  - General total: 2·(3·2**AW)+1 cycles.
- `start` held high continuously: a new run begins on the edge after DONE, i.e. cycle 26 is IDLE and samples `start`.
- `err_count` width AW+2 holds the maximum 2·2**AW mismatches without overflow.

## Test plan
- Fault-free RAM, PATTERN=A5, pulse `start`:
  - Writes A5,A4,A7,A6 to addr 0–3, then 5A,5B,58,59.
  - `done` pulses in cycle 25; `pass`=1, `err_count`=0.
- RAM model with bit 0 of addr 2 stuck at 1:
  - Pass 0 reads A7 (no error); pass 1 reads 59 for expected 58.
  - `err_count`=1, `fail_addr`=2, `fail_pass`=1, `pass`=0.
- Data bus bit 7 stuck at 0 on all addresses:
  - All 4 pass-0 compares fail.
  - `err_count`=4, `fail_addr`=0, `fail_pass`=0.
- `rst` asserted in cycle 10:
  - Next cycle: all outputs zero, state IDLE.
  - A new `start` then completes normally with `pass`=1.
- `start` re-pulsed during cycles 3 and 20:
  - Ignored; single `done` in cycle 25.
  - With `start` then held high, a second run begins immediately after DONE.

Source files
------------

// File: rtl/ram_bist.sv
// Purpose: built-in self-test initiator; two-pass write/read-back/compare sweep of a small single-port RAM.
// Latency: 2*(3*2**AW)+1 cycles from accepted start to the one-cycle done pulse; all outputs registered.
// Backpressure: none; start is sampled only in IDLE and ignored while a run is in progress.
module ram_bist #(
    parameter int              AW      = 2,
    parameter int              DW      = 8,
    parameter logic [DW-1:0]   PATTERN = 8'hA5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            ram_we_o,
    output logic [AW-1:0]   ram_addr_o,
    output logic [DW-1:0]   ram_din_o,
    input  logic [DW-1:0]   ram_dout_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [AW+1:0]   err_count_o,
    output logic [AW-1:0]   fail_addr_o,
    output logic            fail_pass_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    // Pass 0 writes PATTERN xor address; pass 1 writes the bitwise inverse.
    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input logic p);
        logic [DW-1:0] d;
        d = PATTERN ^ DW'(a);
        return p ? ~d : d;
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            pidx_q, pidx_d;
    logic [AW+1:0]   err_q, err_d;
    logic [AW-1:0]   faddr_q, faddr_d;
    logic            fpass_q, fpass_d;
    logic            pass_q, pass_d;
    logic            we_q, we_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [DW-1:0]   din_q, din_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            mismatch;

    // Next-state, sweep bookkeeping, and the registered RAM-side/status outputs derived from the next state.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pidx_d   = pidx_q;
        err_d    = err_q;
        faddr_d  = faddr_q;
        fpass_d  = fpass_q;
        pass_d   = pass_q;
        mismatch = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_WR;
                    addr_d  = '0;
                    pidx_d  = 1'b0;
                    err_d   = '0;
                    faddr_d = '0;
                    fpass_d = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_WR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_RD;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_RD: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                mismatch = (ram_dout_i != exp_data(addr_q, pidx_q));
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        faddr_d = addr_q;
                        fpass_d = pidx_q;
                    end
                end
                if (addr_q != LAST_ADDR) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_RD;
                end else if (!pidx_q) begin
                    pidx_d  = 1'b1;
                    addr_d  = '0;
                    state_d = S_WR;
                end else begin
                    state_d = S_DONE;
                    // Verdict lands together with done, and includes a mismatch found in this final compare.
                    pass_d  = (err_d == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        we_d    = (state_d == S_WR);
        busy_d  = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_CMP);
        done_d  = (state_d == S_DONE);
        raddr_d = busy_d ? addr_d : '0;
        din_d   = we_d ? exp_data(addr_d, pidx_d) : '0;
    end

    // State and output registers with synchronous reset to the quiescent IDLE condition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            pidx_q  <= 1'b0;
            err_q   <= '0;
            faddr_q <= '0;
            fpass_q <= 1'b0;
            pass_q  <= 1'b0;
            we_q    <= 1'b0;
            raddr_q <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pidx_q  <= pidx_d;
            err_q   <= err_d;
            faddr_q <= faddr_d;
            fpass_q <= fpass_d;
            pass_q  <= pass_d;
            we_q    <= we_d;
            raddr_q <= raddr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ram_we_o    = we_q;
    assign ram_addr_o  = raddr_q;
    assign ram_din_o   = din_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_addr_o = faddr_q;
    assign fail_pass_o = fpass_q;

endmodule

// File: tb/tb_ram_bist.sv
// Purpose: self-checking bench for ram_bist against a faultable behavioural RAM and a sweep-level reference.
// Latency: checks the 25-cycle run profile and done/busy timing for AW=2.
// Backpressure: n/a; exercises start re-pulses, start held high and mid-run reset.
module tb_ram_bist;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       ram_we_o;
    logic [1:0] ram_addr_o;
    logic [7:0] ram_din_o;
    logic [7:0] ram_dout_i;
    logic       busy_o, done_o, pass_o, fail_pass_o;
    logic [3:0] err_count_o;
    logic [1:0] fail_addr_o;

    int n_vec = 0;
    int n_err = 0;

    // RAM storage and per-address read-fault masks: read = (stored & and_m) | or_m.
    logic [7:0] mem   [4];
    logic [7:0] and_m [4];
    logic [7:0] or_m  [4];

    always #5 clk = ~clk;

    ram_bist #(.AW(2), .DW(8), .PATTERN(8'hA5)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_din_o   (ram_din_o),
        .ram_dout_i  (ram_dout_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .err_count_o (err_count_o),
        .fail_addr_o (fail_addr_o),
        .fail_pass_o (fail_pass_o)
    );

    // Behavioural single-port RAM: write when we, otherwise registered (possibly faulty) read.
    always @(posedge clk) begin
        if (ram_we_o) mem[ram_addr_o] <= ram_din_o;
        else          ram_dout_i <= (mem[ram_addr_o] & and_m[ram_addr_o]) | or_m[ram_addr_o];
    end

    function automatic logic [7:0] pat(input int a, input int p);
        logic [7:0] d;
        d = 8'hA5 ^ 8'(a);
        return (p != 0) ? ~d : d;
    endfunction

    task automatic clean_masks();
        for (int a = 0; a < 4; a++) begin
            and_m[a] = 8'hFF;
            or_m[a]  = 8'h00;
        end
    endtask

    // Reference: every pass writes all locations before reading, so a read returns the faulted pattern.
    task automatic ref_model(output int e_err, output int e_fa, output int e_fp, output bit e_pass);
        logic [7:0] e, r;
        e_err = 0; e_fa = 0; e_fp = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 4; a++) begin
                e = pat(a, p);
                r = (e & and_m[a]) | or_m[a];
                if (r != e) begin
                    if (e_err == 0) begin e_fa = a; e_fp = p; end
                    e_err++;
                end
            end
        end
        e_pass = (e_err == 0);
    endtask

    // One full run from a start pulse; checks profile, write sequence and final status.
    task automatic do_run(input string nm, input bit hold, input bit repulse);
        logic [1:0] wadr [8];
        logic [7:0] wdat [8];
        int nw, dcyc, e_err, e_fa, e_fp, bad;
        bit e_pass, busy_ok;
        nw = 0; dcyc = -1; busy_ok = 1; bad = -1;
        ref_model(e_err, e_fa, e_fp, e_pass);
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1 if (!hold) start_i = 1'b0;
        for (int k = 1; k <= 30 && dcyc < 0; k++) begin
            @(negedge clk);
            if (repulse && (k == 3 || k == 20)) start_i = 1'b1;
            else if (!hold) start_i = 1'b0;
            if (ram_we_o === 1'b1) begin
                if (nw < 8) begin wadr[nw] = ram_addr_o; wdat[nw] = ram_din_o; end
                nw++;
            end
            if (done_o === 1'b1) dcyc = k;
            else if (busy_o !== 1'b1) busy_ok = 0;
        end
        n_vec++;
        if (dcyc !== 25) begin n_err++; $display("FAIL %s done_cycle got %0d want 25", nm, dcyc); end
        n_vec++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL %s busy_at_done got %b want 0", nm, busy_o); end
        n_vec++;
        if (!busy_ok) begin n_err++; $display("FAIL %s busy_during_run got gap want continuous", nm); end
        if (nw != 8) bad = 8;
        else for (int i = 0; i < 8; i++)
            if (bad < 0 && (wadr[i] !== 2'(i % 4) || wdat[i] !== pat(i % 4, i / 4))) bad = i;
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s writes count %0d first_bad %0d want 8 writes A5,A4,A7,A6,5A,5B,58,59", nm, nw, bad);
        end
        n_vec++;
        if (err_count_o !== 4'(e_err)) begin n_err++; $display("FAIL %s err_count got %0d want %0d", nm, err_count_o, e_err); end
        n_vec++;
        if (pass_o !== e_pass) begin n_err++; $display("FAIL %s pass got %b want %b", nm, pass_o, e_pass); end
        n_vec++;
        if (fail_addr_o !== 2'(e_fa)) begin n_err++; $display("FAIL %s fail_addr got %0d want %0d", nm, fail_addr_o, e_fa); end
        n_vec++;
        if (fail_pass_o !== 1'(e_fp)) begin n_err++; $display("FAIL %s fail_pass got %b want %0d", nm, fail_pass_o, e_fp); end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ram_we_o, ram_addr_o, ram_din_o, busy_o, done_o, pass_o, err_count_o, fail_addr_o, fail_pass_o} !== '0) begin
            n_err++; $display("FAIL reset_outputs got nonzero (we=%b busy=%b err=%0d) want all 0", ram_we_o, busy_o, err_count_o);
        end
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b0 || ram_we_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++; $display("FAIL idle_quiet got busy=%b we=%b done=%b want 0", busy_o, ram_we_o, done_o);
        end
    endtask

    task automatic test_clean();
        clean_masks();
        do_run("clean", 1'b0, 1'b0);
    endtask

    task automatic test_stuck_cell();
        clean_masks();
        or_m[2] = 8'h01;
        do_run("stuck_cell", 1'b0, 1'b0);
    endtask

    task automatic test_bus_bit7();
        clean_masks();
        for (int a = 0; a < 4; a++) and_m[a] = 8'h7F;
        do_run("bus_bit7", 1'b0, 1'b0);
    endtask

    task automatic test_midrun_reset();
        clean_masks();
        for (int a = 0; a < 4; a++) and_m[a] = 8'h7F;
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        n_vec++;
        if (err_count_o !== 4'd2) begin n_err++; $display("FAIL midrun_err_before_rst got %0d want 2", err_count_o); end
        rst_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({ram_we_o, ram_addr_o, ram_din_o, busy_o, done_o, pass_o, err_count_o, fail_addr_o, fail_pass_o} !== '0) begin
            n_err++; $display("FAIL midrun_reset got busy=%b err=%0d addr=%0d want all 0", busy_o, err_count_o, ram_addr_o);
        end
        rst_i = 1'b0;
        clean_masks();
        @(negedge clk);
        do_run("after_reset", 1'b0, 1'b0);
    endtask

    task automatic test_start_repulse();
        clean_masks();
        do_run("repulse", 1'b0, 1'b1);
        @(negedge clk);
        n_vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL repulse_single_done got done=%b busy=%b want 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        clean_masks();
        for (int a = 0; a < 4; a++) and_m[a] = 8'h7F;
        do_run("b2b_first", 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || ram_we_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle_cycle got busy=%b done=%b we=%b want 0 0 0", busy_o, done_o, ram_we_o);
        end
        @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 2'd0 || ram_din_o !== 8'hA5 || err_count_o !== 4'd0) begin
            n_err++; $display("FAIL b2b_restart got busy=%b we=%b addr=%0d din=%h err=%0d want 1 1 0 a5 0",
                              busy_o, ram_we_o, ram_addr_o, ram_din_o, err_count_o);
        end
        start_i = 1'b0;
        clean_masks();
        t = 0;
        while (done_o !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        n_vec++;
        if (done_o !== 1'b1 || pass_o !== 1'b1 || err_count_o !== 4'd0) begin
            n_err++; $display("FAIL b2b_second got done=%b pass=%b err=%0d want 1 1 0", done_o, pass_o, err_count_o);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            clean_masks();
            for (int a = 0; a < 4; a++) begin
                case ($urandom_range(0, 3))
                    0: and_m[a] = ~(8'h01 << $urandom_range(0, 7));
                    1: or_m[a]  = 8'h01 << $urandom_range(0, 7);
                    2: begin and_m[a] = 8'($urandom) | 8'($urandom); or_m[a] = 8'($urandom) & 8'($urandom); end
                    default: ;
                endcase
            end
            do_run($sformatf("random%0d", it), 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int a = 0; a < 4; a++) mem[a] = 8'h00;
        ram_dout_i = 8'h00;
        clean_masks();
        test_reset();
        test_clean();
        test_stuck_cell();
        test_bus_bit7();
        test_midrun_reset();
        test_start_repulse();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
